// File: rtl/cpu_pkg.sv
// Shared funct3 encodings, FSM state type and latched-request struct for the load/store unit.
package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // addr keeps only the byte-lane offset; the word address goes straight to addr_data.
    typedef struct packed {
        logic        store;
        logic [2:0]  funct3;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store write enables / replicated data and load extraction with extension.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  we,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte     = rdata_raw[{lane, 3'b000} +: 8];
        rhalf     = lane[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        we        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata_raw;
        // Halfwords select on lane[1] only, so a stray lane[0] is silently ignored.
        case (funct3)
            F3_B: begin
                we        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{rbyte[7]}}, rbyte};
            end
            F3_H: begin
                we        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{rhalf[15]}}, rhalf};
            end
            F3_BU:   rdata_ext = {24'b0, rbyte};
            F3_HU:   rdata_ext = {16'b0, rhalf};
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit between the MEMORY stage and a synchronous 32-bit data RAM.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of silently aligning them.
module cpu_lsu
    import cpu_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] addr_data,
    output logic [31:0]       data_out_data,
    input  logic [31:0]       data_in_data,
    output logic              en_data,
    output logic [3:0]        we_data,
    output logic [1:0]        state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid and its payload stay stable until that edge, and ready never waits on valid.

    lsu_state_e  state;
    lsu_req_t    req_q;
    lsu_req_t    align_req;
    logic [2:0]  wait_cnt;
    logic        bad_op;
    logic        reject;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] rext;

    assign state_dbg = state;

    always_comb begin
        if (req_store)
            bad_op = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
        else
            bad_op = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        reject = bad_op
               || ((req_funct3[1:0] == 2'b01) && req_addr[0])
               || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        reject = bad_op;
`endif
    end

    // Store lanes come from the live request in IDLE; load extraction uses the latched one.
    always_comb begin
        if (state == IDLE) begin
            align_req.store  = req_store;
            align_req.funct3 = req_funct3;
            align_req.addr   = req_addr[1:0];
            align_req.wdata  = req_wdata;
        end else begin
            align_req = req_q;
        end
    end

    lsu_align u_align (
        .funct3    (align_req.funct3),
        .lane      (align_req.addr),
        .wdata     (align_req.wdata),
        .rdata_raw (data_in_data),
        .we        (be),
        .wdata_rep (wrep),
        .rdata_ext (rext)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            req_q         <= '0;
            wait_cnt      <= '0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            addr_data     <= '0;
            data_out_data <= '0;
            en_data       <= 1'b0;
            we_data       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        req_q     <= align_req;
                        if (reject) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else begin
                            en_data       <= 1'b1;
                            addr_data     <= {req_addr[ADDR_W-1:2], 2'b00};
                            we_data       <= req_store ? be : 4'b0000;
                            data_out_data <= req_store ? wrep : 32'b0;
                            state         <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    en_data       <= 1'b0;
                    we_data       <= '0;
                    addr_data     <= '0;
                    data_out_data <= '0;
                    if (req_q.store) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= 3'(RD_LATENCY - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= rext;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_lsu.sv
// Bench for cpu_lsu: two instances (RD_LATENCY 1 and 3), each with its own RAM model.
`timescale 1ns/1ps
module tb_cpu_lsu;
    import cpu_pkg::*;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [1:0]  req_valid, req_ready, req_store, rsp_valid, rsp_ready, rsp_err, en_data;
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];
    logic [31:0] addr_data [2];
    logic [31:0] data_out_data [2];
    logic [31:0] data_in_data [2];
    logic [3:0]  we_data [2];
    logic [1:0]  state_dbg [2];

    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    logic [31:0] pipe0 [4];
    logic [31:0] pipe1 [4];
    logic [31:0] ref_mem [2][1024];
    logic        init_mem;

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] init_word(input int d, input int i);
        return 32'(i * 32'h9E3779B1) ^ 32'(d << 16) ^ 32'h5A5A1234;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_lsu #(.RD_LATENCY(g == 0 ? LAT0 : LAT1), .ADDR_W(32)) u_dut (
            .aclk          (aclk),
            .aresetn       (aresetn),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_store     (req_store[g]),
            .req_funct3    (req_funct3[g]),
            .req_addr      (req_addr[g]),
            .req_wdata     (req_wdata[g]),
            .rsp_valid     (rsp_valid[g]),
            .rsp_ready     (rsp_ready[g]),
            .rsp_rdata     (rsp_rdata[g]),
            .rsp_err       (rsp_err[g]),
            .addr_data     (addr_data[g]),
            .data_out_data (data_out_data[g]),
            .data_in_data  (data_in_data[g]),
            .en_data       (en_data[g]),
            .we_data       (we_data[g]),
            .state_dbg     (state_dbg[g])
        );
    end

    // Synchronous RAMs: writes on the enable edge, read data emerges after the instance latency.
    always @(posedge aclk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem0[i] <= init_word(0, i);
        end else if (en_data[0] && we_data[0] != 4'b0) begin
            for (int b = 0; b < 4; b++)
                if (we_data[0][b]) mem0[addr_data[0][11:2]][8*b +: 8] <= data_out_data[0][8*b +: 8];
        end
        for (int i = 3; i > 0; i--) pipe0[i] <= pipe0[i-1];
        pipe0[0] <= (en_data[0] && we_data[0] == 4'b0) ? mem0[addr_data[0][11:2]] : 32'h0;
    end

    always @(posedge aclk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= init_word(1, i);
        end else if (en_data[1] && we_data[1] != 4'b0) begin
            for (int b = 0; b < 4; b++)
                if (we_data[1][b]) mem1[addr_data[1][11:2]][8*b +: 8] <= data_out_data[1][8*b +: 8];
        end
        for (int i = 3; i > 0; i--) pipe1[i] <= pipe1[i-1];
        pipe1[0] <= (en_data[1] && we_data[1] == 4'b0) ? mem1[addr_data[1][11:2]] : 32'h0;
    end

    assign data_in_data[0] = pipe0[LAT0-1];
    assign data_in_data[1] = pipe1[LAT1-1];

    function automatic logic [31:0] mem_word(input int d, input int idx);
        return (d == 0) ? mem0[idx] : mem1[idx];
    endfunction

    // Reference: access size 1/2/4 bytes at an offset aligned down to that size.
    task automatic model(input int d, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output bit err, output logic [31:0] rd,
                         output logic [3:0] we, output logic [31:0] dout);
        int idx, size, off;
        logic [31:0] w;
        longint unsigned v, m;
        idx  = int'(a[11:2]);
        size = 1 << f3[1:0];
        err  = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!err && (int'(a[1:0]) % size) != 0) err = 1'b1;
`endif
        rd = 32'h0; we = 4'h0; dout = 32'h0;
        if (!err) begin
            off = (int'(a[1:0]) / size) * size;
            w   = ref_mem[d][idx];
            if (st) begin
                for (int i = 0; i < size; i++) begin
                    w[8*(off+i) +: 8] = wd[8*i +: 8];
                    we[off+i] = 1'b1;
                end
                for (int j = 0; j < 4; j++) dout[8*j +: 8] = wd[8*(j % size) +: 8];
                ref_mem[d][idx] = w;
            end else begin
                m = (64'd1 << (8*size)) - 64'd1;
                v = (longint'(w) >> (8*off)) & m;
                if (!f3[2] && v[8*size-1]) v = v | ~m;
                rd = v[31:0];
            end
        end
    endtask

    task automatic do_txn(input int d, input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold);
        bit          e_err, got;
        logic [31:0] e_rd, e_dout;
        logic [3:0]  e_we;
        int          lat, k;
        model(d, st, f3, a, wd, e_err, e_rd, e_we, e_dout);
        lat = e_err ? 1 : (st ? 2 : 2 + (d == 0 ? LAT0 : LAT1));
        req_valid[d] = 1'b1; req_store[d] = st; req_funct3[d] = f3;
        req_addr[d] = a; req_wdata[d] = wd;
        tests++;
        if (req_ready[d] !== 1'b1) begin
            fails++; $display("FAIL req_ready_idle d=%0d got=%b exp=1", d, req_ready[d]);
        end
        @(negedge aclk);
        req_valid[d] = 1'b0;
        k = 1; got = 1'b0;
        while (!got && k <= 12) begin
            tests++;
            if (en_data[d] !== 1'(!e_err && k == 1)) begin
                fails++; $display("FAIL en_data d=%0d a=%h k=%0d got=%b", d, a, k, en_data[d]);
            end
            tests++;
            if (req_ready[d] !== 1'b0) begin
                fails++; $display("FAIL req_ready_busy d=%0d k=%0d got=%b exp=0", d, k, req_ready[d]);
            end
            if (!e_err && k == 1) begin
                tests++;
                if (addr_data[d] !== (a & 32'hFFFF_FFFC)) begin
                    fails++; $display("FAIL addr_data d=%0d got=%h exp=%h", d, addr_data[d], a & 32'hFFFF_FFFC);
                end
                tests++;
                if (we_data[d] !== e_we) begin
                    fails++; $display("FAIL we_data d=%0d a=%h got=%b exp=%b", d, a, we_data[d], e_we);
                end
                if (st) begin
                    tests++;
                    if (data_out_data[d] !== e_dout) begin
                        fails++; $display("FAIL data_out d=%0d got=%h exp=%h", d, data_out_data[d], e_dout);
                    end
                end
            end
            if (rsp_valid[d]) begin
                got = 1'b1;
                tests++;
                if (k != lat) begin
                    fails++; $display("FAIL latency d=%0d a=%h f3=%0d got=%0d exp=%0d", d, a, f3, k, lat);
                end
                tests++;
                if (rsp_rdata[d] !== e_rd || rsp_err[d] !== e_err) begin
                    fails++; $display("FAIL rsp d=%0d a=%h f3=%0d st=%0d got=%h/%b exp=%h/%b",
                                      d, a, f3, st, rsp_rdata[d], rsp_err[d], e_rd, e_err);
                end
            end else begin
                k++;
                @(negedge aclk);
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL rsp_timeout d=%0d a=%h got=no_rsp exp=rsp_at_%0d", d, a, lat);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge aclk);
            tests++;
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== e_rd || rsp_err[d] !== e_err
                || req_ready[d] !== 1'b0 || en_data[d] !== 1'b0) begin
                fails++; $display("FAIL rsp_hold d=%0d h=%0d got=%b/%h/%b/%b exp=1/%h/%b/0",
                                  d, h, rsp_valid[d], rsp_rdata[d], rsp_err[d], req_ready[d], e_rd, e_err);
            end
        end
        rsp_ready[d] = 1'b1;
        @(negedge aclk);
        rsp_ready[d] = 1'b0;
        tests++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            fails++; $display("FAIL rsp_release d=%0d got=%b/%b exp=0/1", d, rsp_valid[d], req_ready[d]);
        end
        if (st && !e_err) begin
            tests++;
            if (mem_word(d, int'(a[11:2])) !== ref_mem[d][int'(a[11:2])]) begin
                fails++; $display("FAIL mem_word d=%0d a=%h got=%h exp=%h", d, a,
                                  mem_word(d, int'(a[11:2])), ref_mem[d][int'(a[11:2])]);
            end
        end
    endtask

    task automatic test_reset();
        init_mem = 1'b1;
        repeat (2) @(negedge aclk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({req_ready[d], rsp_valid[d], rsp_err[d], en_data[d], we_data[d]} !== 8'h0
                || addr_data[d] !== 32'h0 || data_out_data[d] !== 32'h0 || rsp_rdata[d] !== 32'h0) begin
                fails++; $display("FAIL reset_outputs d=%0d got=%b%b%b%b/%h exp=all_zero",
                                  d, req_ready[d], rsp_valid[d], rsp_err[d], en_data[d], we_data[d]);
            end
        end
        init_mem = 1'b0;
        aresetn  = 1'b1;
        @(negedge aclk);
        tests++;
        if (req_ready !== 2'b11) begin
            fails++; $display("FAIL reset_release_ready got=%b exp=11", req_ready);
        end
    endtask

    task automatic test_directed(input int d);
        do_txn(d, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0);
        do_txn(d, 1'b1, F3_B, 32'h103, 32'h000000A5, 1);
        do_txn(d, 1'b1, F3_W, 32'h200, 32'h80FF7F01, 0);
        do_txn(d, 1'b0, F3_B,  32'h203, 32'h0, 0);
        do_txn(d, 1'b0, F3_BU, 32'h203, 32'h0, 0);
        do_txn(d, 1'b0, F3_H,  32'h202, 32'h0, 2);
        do_txn(d, 1'b0, F3_HU, 32'h200, 32'h0, 0);
        do_txn(d, 1'b0, F3_W,  32'h200, 32'h0, 0);
    endtask

    task automatic test_misalign(input int d);
        do_txn(d, 1'b0, F3_W, 32'h102, 32'h0, 0);
        do_txn(d, 1'b0, F3_H, 32'h201, 32'h0, 0);
        do_txn(d, 1'b1, F3_H, 32'h305, 32'h0000BEEF, 0);
    endtask

    task automatic test_invalid(input int d);
        do_txn(d, 1'b0, 3'b011, 32'h10, 32'h0, 5);
        do_txn(d, 1'b1, 3'b100, 32'h20, 32'h12345678, 0);
    endtask

    task automatic test_back_to_back();
        int acc, rv;
        bit e_err; logic [31:0] e_rd, e_dout; logic [3:0] e_we;
        model(0, 1'b1, F3_W, 32'h300, 32'h13579BDF, e_err, e_rd, e_we, e_dout);
        acc = 0; rv = 0;
        req_valid[0] = 1'b1; req_store[0] = 1'b1; req_funct3[0] = F3_W;
        req_addr[0] = 32'h300; req_wdata[0] = 32'h13579BDF; rsp_ready[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (req_valid[0] && req_ready[0]) acc++;
            if (rsp_valid[0]) rv++;
            @(negedge aclk);
        end
        req_valid[0] = 1'b0; rsp_ready[0] = 1'b0;
        tests++;
        if (acc != 4 || rv != 4) begin
            fails++; $display("FAIL back_to_back got=%0d/%0d exp=4/4", acc, rv);
        end
        @(negedge aclk);
        tests++;
        if (mem0[192] !== ref_mem[0][192]) begin
            fails++; $display("FAIL b2b_mem got=%h exp=%h", mem0[192], ref_mem[0][192]);
        end
    endtask

    // Reset mid-access: stores are hit in ACCESS, loads in WAIT.
    task automatic test_reset_mid(input int d, input bit st);
        req_valid[d] = 1'b1; req_store[d] = st; req_funct3[d] = F3_W;
        req_addr[d] = 32'h44; req_wdata[d] = ~ref_mem[d][17];
        @(negedge aclk);
        req_valid[d] = 1'b0;
        if (!st) @(negedge aclk);
        tests++;
        if (state_dbg[d] !== (st ? 2'(ACCESS) : 2'(WAIT)) || en_data[d] !== st) begin
            fails++; $display("FAIL pre_reset_state d=%0d got=%0d/%b exp=%0d", d, state_dbg[d], en_data[d],
                              st ? 1 : 2);
        end
        #2 aresetn = 1'b0;
        #1;
        tests++;
        if (en_data[d] !== 1'b0 || we_data[d] !== 4'h0 || rsp_valid[d] !== 1'b0
            || req_ready[d] !== 1'b0 || state_dbg[d] !== 2'(IDLE)) begin
            fails++; $display("FAIL async_reset d=%0d got=%b/%b/%b/%b/%0d exp=0/0/0/0/0",
                              d, en_data[d], we_data[d], rsp_valid[d], req_ready[d], state_dbg[d]);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        tests++;
        if (req_ready[d] !== 1'b1) begin
            fails++; $display("FAIL post_reset_ready d=%0d got=%b exp=1", d, req_ready[d]);
        end
        rsp_ready[d] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tests++;
            if (rsp_valid[d] !== 1'b0) begin
                fails++; $display("FAIL stale_rsp d=%0d c=%0d got=%b exp=0", d, c, rsp_valid[d]);
            end
            @(negedge aclk);
        end
        rsp_ready[d] = 1'b0;
        tests++;
        if (mem_word(d, 17) !== ref_mem[d][17]) begin
            fails++; $display("FAIL aborted_mem d=%0d got=%h exp=%h", d, mem_word(d, 17), ref_mem[d][17]);
        end
    endtask

    task automatic test_random(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge aclk);
            do_txn(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 4095)), $urandom, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        req_valid = '0; req_store = '0; rsp_ready = '0; init_mem = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_funct3[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
            for (int i = 0; i < 1024; i++) ref_mem[d][i] = init_word(d, i);
        end
        test_reset();
        test_directed(0);
        test_directed(1);
        test_misalign(0);
        test_misalign(1);
        test_invalid(0);
        test_invalid(1);
        test_back_to_back();
        test_reset_mid(0, 1'b1);
        test_reset_mid(1, 1'b0);
        do_txn(1, 1'b0, F3_W, 32'h200, 32'h0, 0);
        test_random(0, 40);
        test_random(1, 40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_lsu.md
Name: cpu_lsu

Overview:
- Load/store unit between the core's MEMORY stage and the 32-bit data-memory port (addr_data/data_out_data/data_in_data/en_data/we_data).
- Accepts one load or store request per transaction over a valid/ready handshake.
- Generates byte-lane write enables and replicated write data; extracts and sign/zero-extends load data; returns the result over a valid/ready response channel.
- Memory is synchronous RAM with fixed read latency.

Parameters:
RD_LATENCY  1   data-memory read latency in cycles after the en_data cycle; legal 1..4
ADDR_W      32  byte-address width

Ports:
aclk           in   1       clock, rising edge
aresetn        in   1       asynchronous active-low reset
req_valid      in   1       request valid
req_ready      out  1       LSU can accept a request
req_store      in   1       1 = store, 0 = load
req_funct3     in   3       RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr       in   ADDR_W  byte address (already computed by the core)
req_wdata      in   32      store data (rs2 value)
rsp_valid      out  1       response valid
rsp_ready      in   1       core accepts response
rsp_rdata      out  32      extended load data; 0 for stores and errors
rsp_err        out  1       request rejected; no memory access performed
addr_data      out  ADDR_W  byte address to memory, bits [1:0] forced to 00
data_out_data  out  32      store data, lane-replicated
data_in_data   in   32      read data from memory
en_data        out  1       memory enable
we_data        out  4       byte write enables; bit i = byte lane i (little-endian)

Behaviour:
- Reset (aresetn low, asynchronous) forces all outputs to 0 and state to IDLE immediately.
  - req_ready rises in the first cycle after release.
  - An in-flight access is abandoned: en_data and we_data drop asynchronously, and no response is issued.
- States: IDLE, ACCESS, WAIT, RESP. All memory-side outputs are registered.
- IDLE:
  - req_ready=1. A request is taken on a cycle with req_valid && req_ready.
  - If the request is invalid or misaligned: latch rsp_err=1, rsp_rdata=0, go to RESP. No memory cycle is issued.
  - Otherwise latch the operation, go to ACCESS.
- ACCESS: exactly one cycle.
  - en_data=1, addr_data={req_addr[ADDR_W-1:2],2'b00}.
  - Store: we_data=SB 4'b0001<<a[1:0], SH 4'b0011<<a[1:0], SW 4'b1111. data_out_data=SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata. Next state is RESP.
  - Load: we_data=0, next state is WAIT.
- WAIT:
  - A counter runs RD_LATENCY cycles after the ACCESS cycle; en_data=0.
  - data_in_data is sampled on the edge that ends the last WAIT cycle.
  - Lane select is a[1:0]. LB/LBU byte lane sign/zero-extended; LH/LHU halfword at a[1] sign/zero-extended; LW whole word.
  - Next state is RESP.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, return to IDLE. req_ready stays 0 in that cycle (no same-cycle turnaround).
- Latency from accept edge to rsp_valid:
  - store: 2 cycles
  - load: 2+RD_LATENCY cycles
  - error: 1 cycle
- Invalid operations (always rsp_err=1, independent of the macro):
  - store funct3 other than 000/001/010
  - load funct3 011, 110, 111
- Misalignment: halfword with a[0]=1; word with a[1:0]!=00.
- rsp_ready held high in RESP gives back-to-back throughput of one store per 3 cycles.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses are rejected with rsp_err=1 and no memory access.
- Undefined:
  - Misaligned accesses are silently aligned: halfword uses a[1] with a[0] ignored; word ignores a[1:0].
  - The access proceeds normally.
  - rsp_err is asserted only for invalid funct3.

Decomposition:
- Package cpu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - typedef enum lsu_state_e {IDLE, ACCESS, WAIT, RESP}
  - typedef struct lsu_req_t {store, funct3, addr, wdata}
- Sub-module lsu_align (combinational): computes we_data/data_out_data for stores and extended rdata for loads from funct3, a[1:0] and the raw word. cpu_lsu keeps the FSM, counter and handshakes.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF -> ACCESS cycle: en_data=1, we_data=1111, addr_data=0x100, data_out_data=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_err=0.
- SB addr 0x103, wdata 0x000000A5 -> we_data=1000, data_out_data=0xA5A5A5A5.
- memory word 0x80FF7F01 at 0x200; LB 0x203 -> 0xFFFFFF80; LBU 0x203 -> 0x00000080; LH 0x202 -> 0xFFFF80FF; LHU 0x200 -> 0x00007F01. rsp_valid at 2+RD_LATENCY cycles, checked with RD_LATENCY=1 and 3.
- LW addr 0x102 -> with LSU_MISALIGN_TRAP_EN: rsp_err=1, rsp_rdata=0, en_data never asserted. Without: reads word 0x100.
- req_funct3=011 load -> rsp_err=1 after 1 cycle, no en_data. rsp_ready held low 5 cycles -> rsp_valid and data stable, req_ready=0 throughout.
- Assert aresetn low during the WAIT of a load -> en_data/we_data/rsp_valid go 0 asynchronously; after release, req_ready=1 and no stale response.
